loopbuffer_queue: RTL and testbench

//  Parametrised instruction queue between fetch and decode; successor to the fixed 32-entry loop buffer.
//  - Each instruction is tagged with a 3-bit fault code at enqueue.
//  - Fetch is throttled by a programmable watermark.
//  - After the first faulting instruction, further enqueues are blocked until a flush (wrong-path suppression).
//  - Occupancy is exported to the core.

---
 rtl/loopbuffer_queue_pkg.sv | 39 +++
 rtl/loopbuffer_queue_fault_check.sv | 32 +++
 rtl/loopbuffer_queue.sv | 122 ++++++++++++
 tb/tb_loopbuffer_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopbuffer_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Privileged opcode values match the core-wide encoding of inst[30:21].
package loopbuffer_queue_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned FLAGS_W  = 14;
  localparam int unsigned OPC_W    = 10;
  localparam int unsigned FAULT_W  = 3;

  // Fault code bit positions
  localparam int unsigned FAULT_PAGEFAULT = 2;
  localparam int unsigned FAULT_PRIVILEGE = 1;
  localparam int unsigned FAULT_INVALID   = 0;

  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRTISR  = 10'h1A0;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRKPDTR = 10'h1A1;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRIEIW  = 10'h1A2;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRTISW  = 10'h1A3;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRKPDTW = 10'h1A4;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_SRMMUW  = 10'h1A5;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_HALT    = 10'h1F0;
  localparam logic [OPC_W-1:0] FAULT_INSTRUCTION_IDTS    = 10'h1F1;

  typedef struct packed {
    logic [FAULT_W-1:0] fault;
    logic               paging;
    logic               kernel;
    logic [INST_W-1:0]  inst;
    logic [INST_W-1:0]  pc;
  } lbq_entry_t;

  function automatic logic is_privileged_opcode(input logic [OPC_W-1:0] opc);
    return (opc == FAULT_INSTRUCTION_SRTISR)  || (opc == FAULT_INSTRUCTION_SRKPDTR) ||
           (opc == FAULT_INSTRUCTION_SRIEIW)  || (opc == FAULT_INSTRUCTION_SRTISW)  ||
           (opc == FAULT_INSTRUCTION_SRKPDTW) || (opc == FAULT_INSTRUCTION_SRMMUW)  ||
           (opc == FAULT_INSTRUCTION_HALT)    || (opc == FAULT_INSTRUCTION_IDTS);
  endfunction

endpackage

// File: rtl/loopbuffer_queue_fault_check.sv
// Combinational fault encoder: one-hot code, pagefault > privilege > invalid.
module loopbuffer_fault_check
  import loopbuffer_queue_pkg::*;
(
  input  logic               i_pagefault,
  input  logic [FLAGS_W-1:0] i_flags,
  input  logic               i_paging,
  input  logic               i_kernel,
  input  logic [OPC_W-1:0]   i_opcode,
  output logic [FAULT_W-1:0] o_fault_c
);

  logic w_pf;
  logic w_priv;
  logic w_inv;
  logic w_unused_flags;

  assign w_pf   = i_pagefault | (i_paging & ~i_flags[0]);
  assign w_inv  = i_paging & i_flags[0] & ~i_flags[3];
  assign w_priv = ~i_kernel &
                  ((i_paging & i_flags[0] & i_flags[3] & (i_flags[5:4] == 2'b00)) |
                   is_privileged_opcode(i_opcode));
  assign w_unused_flags = ^{i_flags[13:6], i_flags[2:1]};

  always_comb begin
    o_fault_c = '0;
    if (w_pf)        o_fault_c[FAULT_PAGEFAULT] = 1'b1;
    else if (w_priv) o_fault_c[FAULT_PRIVILEGE] = 1'b1;
    else if (w_inv)  o_fault_c[FAULT_INVALID]   = 1'b1;
  end

endmodule

// File: rtl/loopbuffer_queue.sv
// Fetch-to-decode instruction ring with watermark throttle and fault hold.
// Define LOOPBUFFER_BYPASS_EN to pass input straight to decode when the queue is empty.
module loopbuffer_queue
  import loopbuffer_queue_pkg::*;
#(
  parameter  int unsigned DEPTH            = 32,
  parameter  int unsigned FETCH_STOP_LEVEL = 26,
  localparam int unsigned COUNT_W          = $clog2(DEPTH) + 1
) (
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iFREE_REFRESH,
  input  logic               iPREVIOUS_INST_VALID,
  input  logic               iPREVIOUS_PAGEFAULT,
  input  logic [13:0]        iPREVIOUS_MMU_FLAGS,
  input  logic               iPREVIOUS_PAGING_ENA,
  input  logic               iPREVIOUS_KERNEL_ACCESS,
  input  logic [31:0]        iPREVIOUS_INST,
  input  logic [31:0]        iPREVIOUS_PC,
  output logic               oPREVIOUS_FETCH_STOP,
  output logic               oPREVIOUS_LOCK,
  output logic               oNEXT_INST_VALID,
  output logic               oNEXT_FAULT_PAGEFAULT,
  output logic               oNEXT_FAULT_PRIVILEGE_ERROR,
  output logic               oNEXT_FAULT_INVALID_INST,
  output logic               oNEXT_PAGING_ENA,
  output logic               oNEXT_KERNEL_ACCESS,
  output logic [31:0]        oNEXT_INST,
  output logic [31:0]        oNEXT_PC,
  input  logic               iNEXT_LOCK,
  output logic [COUNT_W-1:0] oCOUNT
);

  localparam int unsigned IDX_W = COUNT_W - 1;

  logic [COUNT_W-1:0] r_wr_ptr;
  logic [COUNT_W-1:0] r_rd_ptr;
  logic               r_fault_hold;
  lbq_entry_t         r_mem [DEPTH];

  logic [COUNT_W-1:0] w_count;
  logic               w_empty;
  logic               w_full;
  logic [FAULT_W-1:0] w_fault;
  lbq_entry_t         w_in_entry;
  lbq_entry_t         w_out_entry;
  logic               w_offer;
  logic               w_bypass;
  logic               w_push;
  logic               w_pop;

  loopbuffer_fault_check u_fault_check (
    .i_pagefault (iPREVIOUS_PAGEFAULT),
    .i_flags     (iPREVIOUS_MMU_FLAGS),
    .i_paging    (iPREVIOUS_PAGING_ENA),
    .i_kernel    (iPREVIOUS_KERNEL_ACCESS),
    .i_opcode    (iPREVIOUS_INST[30:21]),
    .o_fault_c   (w_fault)
  );

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

  assign w_in_entry = '{fault:  w_fault,
                        paging: iPREVIOUS_PAGING_ENA,
                        kernel: iPREVIOUS_KERNEL_ACCESS,
                        inst:   iPREVIOUS_INST,
                        pc:     iPREVIOUS_PC};

  // An accepted offer either enters the ring or, with bypass, goes straight out
  assign w_offer = iPREVIOUS_INST_VALID & ~w_full & ~r_fault_hold & ~iFREE_REFRESH;
`ifdef LOOPBUFFER_BYPASS_EN
  assign w_bypass = w_empty & ~iNEXT_LOCK & w_offer;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_push = w_offer & ~w_bypass;
  assign w_pop  = ~w_empty & ~iNEXT_LOCK & ~iFREE_REFRESH;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fault_hold <= 1'b0;
    end else if (iFREE_REFRESH) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fault_hold <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + COUNT_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + COUNT_W'(1);
      if (w_offer && (w_fault != '0)) r_fault_hold <= 1'b1;
    end
  end

  // Ring storage needs no reset: it is only read while non-empty
  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_in_entry;
  end

  always_comb begin
    w_out_entry = '0;
    if (w_bypass)      w_out_entry = w_in_entry;
    else if (!w_empty) w_out_entry = r_mem[r_rd_ptr[IDX_W-1:0]];
  end

  assign oNEXT_INST_VALID            = w_pop | w_bypass;
  assign oNEXT_FAULT_PAGEFAULT       = w_out_entry.fault[FAULT_PAGEFAULT];
  assign oNEXT_FAULT_PRIVILEGE_ERROR = w_out_entry.fault[FAULT_PRIVILEGE];
  assign oNEXT_FAULT_INVALID_INST    = w_out_entry.fault[FAULT_INVALID];
  assign oNEXT_PAGING_ENA            = w_out_entry.paging;
  assign oNEXT_KERNEL_ACCESS         = w_out_entry.kernel;
  assign oNEXT_INST                  = w_out_entry.inst;
  assign oNEXT_PC                    = w_out_entry.pc;

  assign oPREVIOUS_LOCK       = w_full | r_fault_hold;
  assign oPREVIOUS_FETCH_STOP = (w_count > COUNT_W'(FETCH_STOP_LEVEL));
  assign oCOUNT               = w_count;

endmodule

// File: tb/tb_loopbuffer_queue.sv
// Randomised and directed bench for loopbuffer_queue against a queue-based model.
module tb_loopbuffer_queue;
  import loopbuffer_queue_pkg::*;

  localparam int DEPTH = 32;
  localparam int STOP  = 26;
  localparam int CW    = 6;
`ifdef LOOPBUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk, rst_n, refresh, in_valid, in_pf, in_paging, in_kernel, nlock;
  logic [13:0]   in_flags;
  logic [31:0]   in_inst, in_pc;
  logic          o_stop, o_lock, o_valid, o_pf, o_priv, o_inv, o_paging, o_kernel;
  logic [31:0]   o_inst, o_pc;
  logic [CW-1:0] o_count;

  loopbuffer_queue #(.DEPTH(DEPTH), .FETCH_STOP_LEVEL(STOP)) dut (
    .iCLOCK(clk), .inRESET(rst_n), .iFREE_REFRESH(refresh),
    .iPREVIOUS_INST_VALID(in_valid), .iPREVIOUS_PAGEFAULT(in_pf),
    .iPREVIOUS_MMU_FLAGS(in_flags), .iPREVIOUS_PAGING_ENA(in_paging),
    .iPREVIOUS_KERNEL_ACCESS(in_kernel), .iPREVIOUS_INST(in_inst),
    .iPREVIOUS_PC(in_pc), .oPREVIOUS_FETCH_STOP(o_stop), .oPREVIOUS_LOCK(o_lock),
    .oNEXT_INST_VALID(o_valid), .oNEXT_FAULT_PAGEFAULT(o_pf),
    .oNEXT_FAULT_PRIVILEGE_ERROR(o_priv), .oNEXT_FAULT_INVALID_INST(o_inv),
    .oNEXT_PAGING_ENA(o_paging), .oNEXT_KERNEL_ACCESS(o_kernel),
    .oNEXT_INST(o_inst), .oNEXT_PC(o_pc), .iNEXT_LOCK(nlock), .oCOUNT(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit [2:0]  fault;
    bit        paging;
    bit        kernel;
    bit [31:0] inst;
    bit [31:0] pc;
  } m_entry_t;

  m_entry_t  m_q[$];
  bit        m_hold;
  bit [31:0] log_pc[$];
  bit [2:0]  log_fault[$];
  bit        s_valid;
  bit [31:0] s_pc;
  int        n_tests = 0;
  int        n_fail  = 0;

  bit [9:0] priv_ops[8] = '{FAULT_INSTRUCTION_SRTISR, FAULT_INSTRUCTION_SRKPDTR,
                            FAULT_INSTRUCTION_SRIEIW, FAULT_INSTRUCTION_SRTISW,
                            FAULT_INSTRUCTION_SRKPDTW, FAULT_INSTRUCTION_SRMMUW,
                            FAULT_INSTRUCTION_HALT, FAULT_INSTRUCTION_IDTS};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [2:0] model_fault(bit pf, bit [13:0] fl, bit pg, bit k, bit [31:0] inst);
    bit priv_op = 1'b0;
    bit [9:0] opc = inst[30:21];
    foreach (priv_ops[j]) if (opc == priv_ops[j]) priv_op = 1'b1;
    if (pf || (pg && !fl[0])) return 3'b100;
    if (!k && ((pg && fl[0] && fl[3] && fl[5:4] == 2'b00) || priv_op)) return 3'b010;
    if (pg && fl[0] && !fl[3]) return 3'b001;
    return 3'b000;
  endfunction

  // One clock: compare at negedge against the model, then advance the model
  task automatic cycle();
    m_entry_t e;
    bit full, empty, offer, byp, pop;
    @(negedge clk);
    e.fault  = model_fault(in_pf, in_flags, in_paging, in_kernel, in_inst);
    e.paging = in_paging;
    e.kernel = in_kernel;
    e.inst   = in_inst;
    e.pc     = in_pc;
    full  = (m_q.size() == DEPTH);
    empty = (m_q.size() == 0);
    offer = in_valid && !full && !m_hold && !refresh;
    byp   = BYP && empty && !nlock && offer;
    pop   = !empty && !nlock && !refresh;
    chk("valid", o_valid, pop || byp);
    chk("lock", o_lock, full || m_hold);
    chk("fetch_stop", o_stop, m_q.size() > STOP);
    chk("count", o_count, m_q.size());
    if (byp || !empty) begin
      m_entry_t h = byp ? e : m_q[0];
      chk("pc", o_pc, h.pc);
      chk("inst", o_inst, h.inst);
      chk("fault", {o_pf, o_priv, o_inv}, h.fault);
      chk("paging", o_paging, h.paging);
      chk("kernel", o_kernel, h.kernel);
    end
    s_valid = o_valid;
    s_pc    = o_pc;
    if (o_valid) begin
      log_pc.push_back(o_pc);
      log_fault.push_back({o_pf, o_priv, o_inv});
    end
    if (refresh) begin
      m_q.delete();
      m_hold = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (offer && !byp) m_q.push_back(e);
      if (offer && e.fault != 3'b000) m_hold = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic benign(input bit v, input bit [31:0] pc);
    in_valid  = v;
    in_pc     = pc;
    in_inst   = {1'b0, 10'h001, 5'h0, pc[15:0]};
    in_kernel = 1'b1;
    in_paging = 1'b1;
    in_flags  = 14'h0009;
    in_pf     = 1'b0;
  endtask

  task automatic do_refresh();
    in_valid = 1'b0;
    refresh  = 1'b1;
    cycle();
    refresh  = 1'b0;
  endtask

  initial begin
    m_hold = 1'b0;
    rst_n = 1'b0; refresh = 1'b0; nlock = 1'b0;
    benign(1'b0, 32'h0);

    // Reset state
    @(negedge clk);
    chk("rst_count", o_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_lock", o_lock, 0);
    chk("rst_stop", o_stop, 0);
    chk("rst_pc", o_pc, 0);
    chk("rst_inst", o_inst, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();

    // Fill with decode stalled
    nlock = 1'b1;
    for (int i = 0; i < 40; i++) begin
      benign(1'b1, 32'h1000 + 32'(4 * i));
      cycle();
      if (i == 25) chk("stop_at_26", o_stop, 0);
      if (i == 26) chk("stop_at_27", o_stop, 1);
      if (i == 30) chk("lock_at_31", o_lock, 0);
      if (i == 31) chk("lock_at_32", o_lock, 1);
    end
    chk("fill_count", o_count, 32);
    chk("fill_lock", o_lock, 1);
    chk("fill_stop", o_stop, 1);
    do_refresh();
    chk("refresh_count", o_count, 0);

    // Drain order
    log_pc.delete(); log_fault.delete();
    for (int i = 0; i < 8; i++) begin
      benign(1'b1, 32'h100 + 32'(4 * i));
      cycle();
    end
    benign(1'b0, 32'h0);
    nlock = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk("drain_n", log_pc.size(), 8);
    for (int i = 0; i < 8 && i < log_pc.size(); i++)
      chk("drain_pc", log_pc[i], 32'h100 + 32'(4 * i));

    // Fault hold on a user-mode HALT at the third push
    log_pc.delete(); log_fault.delete();
    nlock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      benign(1'b1, 32'h400 + 32'(4 * i));
      in_kernel = 1'b0; in_paging = 1'b0; in_flags = 14'h0;
      if (i == 2) in_inst = {1'b0, FAULT_INSTRUCTION_HALT, 21'h0};
      cycle();
    end
    chk("hold_count", o_count, 3);
    chk("hold_lock", o_lock, 1);
    nlock = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    chk("hold_out_n", log_fault.size(), 3);
    if (log_fault.size() == 3) begin
      chk("hold_f0", log_fault[0], 3'b000);
      chk("hold_f1", log_fault[1], 3'b000);
      chk("hold_f2", log_fault[2], 3'b010);
    end
    chk("hold_lock_drained", o_lock, 1);
    chk("hold_dropped", o_count, 0);
    do_refresh();
    chk("hold_cleared", o_lock, 0);

    // Flush with push and pop requested
    nlock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      benign(1'b1, 32'h600 + 32'(4 * i));
      cycle();
    end
    chk("pre_flush_count", o_count, 10);
    nlock = 1'b0; refresh = 1'b1;
    cycle();
    refresh = 1'b0;
    chk("flush_valid", s_valid, 0);
    chk("flush_count", o_count, 0);
    chk("flush_lock", o_lock, 0);

    // Steady push+pop across pointer wrap
    log_pc.delete(); log_fault.delete();
    nlock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      benign(1'b1, 32'h3000 + 32'(4 * i));
      cycle();
    end
    nlock = 1'b0;
    for (int i = 5; i < 105; i++) begin
      benign(1'b1, 32'h3000 + 32'(4 * i));
      cycle();
    end
    chk("wrap_count", o_count, 5);
    chk("wrap_n", log_pc.size(), 100);
    for (int i = 0; i < log_pc.size(); i++)
      chk("wrap_pc", log_pc[i], 32'h3000 + 32'(4 * i));
    do_refresh();

    // Latency from empty
    benign(1'b0, 32'h0);
    cycle();
    benign(1'b1, 32'h200);
    cycle();
    chk("bypass_valid", s_valid, BYP);
    if (BYP) chk("bypass_pc", s_pc, 32'h200);
    chk("bypass_count", o_count, BYP ? 0 : 1);
    benign(1'b0, 32'h0);
    cycle();
    chk("late_valid", s_valid, !BYP);
    if (!BYP) chk("late_pc", s_pc, 32'h200);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit [9:0] opc;
      refresh   = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      nlock     = ($urandom_range(0, 2) == 0);
      in_pc     = $urandom;
      in_kernel = ($urandom_range(0, 9) < 7);
      in_paging = $urandom_range(0, 1);
      in_pf     = ($urandom_range(0, 32) == 0);
      in_flags  = 14'($urandom);
      if ($urandom_range(0, 19) != 0) in_flags = in_flags | 14'h0009;
      opc = ($urandom_range(0, 9) == 0) ? priv_ops[$urandom_range(0, 7)] : 10'h001;
      in_inst   = $urandom;
      in_inst[30:21] = opc;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
